rr_select_mux: RTL and testbench

//   Parametrised N-channel arbitrating selector for the processor datapath.

---
 rtl/rr_select_mux.sv | 113 +++++++++++
 tb/tb_rr_select_mux.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_select_mux.sv
// N-channel burst-locking arbiter feeding one registered valid/ready output stage.
// Round-robin (MODE 0) or fixed lowest-index priority (MODE 1) channel selection.
module rr_select_mux #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned MODE     = 0,
  localparam int unsigned CH_BITS = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_last,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_last,
  output logic [CH_BITS-1:0]        out_channel,
  input  logic                      out_ready
);

  typedef enum logic {StIdle, StLocked} state_e;

  state_e               state_q;
  logic [CH_BITS-1:0]   ptr_q;
  logic [CH_BITS-1:0]   lock_q;
  logic                 out_valid_q;
  logic [WIDTH-1:0]     out_data_q;
  logic                 out_last_q;
  logic [CH_BITS-1:0]   out_channel_q;

  logic [WIDTH-1:0]     ch_data [CHANNELS];
  logic [CH_BITS-1:0]   grant_idx;
  logic                 grant_vld;
  logic [CH_BITS-1:0]   ptr_nxt;
  logic                 load_en;
  logic                 xfer;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_unpack
    assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
  end

  // Search runs from the highest offset down so the lowest offset wins.
  always_comb begin
    int unsigned        base;
    int unsigned        sum;
    logic [CH_BITS-1:0] cand;
    grant_idx = '0;
    grant_vld = 1'b0;
    base      = (MODE == 0) ? 32'(ptr_q) : 32'd0;
    sum       = 0;
    cand      = '0;
    if (state_q == StLocked) begin
      grant_idx = lock_q;
      grant_vld = in_valid[lock_q];
    end else begin
      for (int k = int'(CHANNELS) - 1; k >= 0; k--) begin
        sum = base + 32'(k);
        if (sum >= CHANNELS) sum = sum - CHANNELS;
        cand = CH_BITS'(sum);
        if (in_valid[cand]) begin
          grant_idx = cand;
          grant_vld = 1'b1;
        end
      end
    end
  end

  assign load_en = !out_valid_q || out_ready;
  assign xfer    = load_en && grant_vld && !reset;
  assign ptr_nxt = (grant_idx == CH_BITS'(CHANNELS - 1)) ? '0 : grant_idx + 1'b1;

  always_comb begin
    in_ready = '0;
    if (xfer) in_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      ptr_q         <= '0;
      lock_q        <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_last_q    <= 1'b0;
      out_channel_q <= '0;
    end else begin
      if (load_en) begin
        out_valid_q <= xfer;
        if (xfer) begin
          out_data_q    <= ch_data[grant_idx];
          out_last_q    <= in_last[grant_idx];
          out_channel_q <= grant_idx;
        end
      end
      if (xfer) begin
        if (in_last[grant_idx]) begin
          state_q <= StIdle;
          ptr_q   <= ptr_nxt;
        end else begin
          state_q <= StLocked;
          lock_q  <= grant_idx;
        end
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_last    = out_last_q;
  assign out_channel = out_channel_q;

endmodule

// File: tb/tb_rr_select_mux.sv
// Directed bench for rr_select_mux: 4-ch round-robin, 8-ch round-robin wrap,
// and 4-ch fixed-priority instances share one clock and reset.
module tb_rr_select_mux;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  logic [3:0]  a_valid, a_last, a_ready;
  logic [63:0] a_data;
  logic        a_ovalid, a_olast, a_oready;
  logic [15:0] a_odata;
  logic [1:0]  a_och;

  logic [7:0]   b_valid, b_last, b_ready;
  logic [127:0] b_data;
  logic         b_ovalid, b_olast, b_oready;
  logic [15:0]  b_odata;
  logic [2:0]   b_och;

  logic [3:0]  c_valid, c_last, c_ready;
  logic [63:0] c_data;
  logic        c_ovalid, c_olast, c_oready;
  logic [15:0] c_odata;
  logic [1:0]  c_och;

  rr_select_mux #(.WIDTH(16), .CHANNELS(4), .MODE(0)) u_a (
    .clock(clk), .reset(reset), .in_valid(a_valid), .in_data(a_data), .in_last(a_last),
    .in_ready(a_ready), .out_valid(a_ovalid), .out_data(a_odata), .out_last(a_olast),
    .out_channel(a_och), .out_ready(a_oready)
  );

  rr_select_mux #(.WIDTH(16), .CHANNELS(8), .MODE(0)) u_b (
    .clock(clk), .reset(reset), .in_valid(b_valid), .in_data(b_data), .in_last(b_last),
    .in_ready(b_ready), .out_valid(b_ovalid), .out_data(b_odata), .out_last(b_olast),
    .out_channel(b_och), .out_ready(b_oready)
  );

  rr_select_mux #(.WIDTH(16), .CHANNELS(4), .MODE(1)) u_c (
    .clock(clk), .reset(reset), .in_valid(c_valid), .in_data(c_data), .in_last(c_last),
    .in_ready(c_ready), .out_valid(c_ovalid), .out_data(c_odata), .out_last(c_olast),
    .out_channel(c_och), .out_ready(c_oready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    a_valid = '0; a_last = '0; a_data = '0; a_oready = 1'b0;
    b_valid = '0; b_last = '0; b_data = '0; b_oready = 1'b0;
    c_valid = '0; c_last = '0; c_data = '0; c_oready = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    clear_inputs();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b1;
    a_valid = 4'hF;
    #1;
    checks++;
    if (a_ovalid !== 1'b0 || a_odata !== 16'h0 || a_och !== 2'd0 || a_olast !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b d=%h ch=%0d l=%b exp 0 0 0 0",
               a_ovalid, a_odata, a_och, a_olast);
    end
    checks++;
    if (a_ready !== 4'b0000) begin
      failures++;
      $display("FAIL reset_in_ready got=%b exp=0000", a_ready);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (a_ready !== 4'b0001) begin
      failures++;
      $display("FAIL reset_first_grant got=%b exp=0001", a_ready);
    end
    // Lock onto ch2 with a held output beat, then reset mid-burst.
    a_valid = 4'b0100; a_last = 4'b0000; a_data[32 +: 16] = 16'h00A0; a_oready = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (a_ovalid !== 1'b1 || a_och !== 2'd2) begin
      failures++;
      $display("FAIL midburst_setup got v=%b ch=%0d exp v=1 ch=2", a_ovalid, a_och);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (a_ovalid !== 1'b0 || a_ready !== 4'b0000) begin
      failures++;
      $display("FAIL midburst_reset got v=%b rdy=%b exp v=0 rdy=0000", a_ovalid, a_ready);
    end
    a_valid = 4'b0101;
    reset = 1'b0;
    #1;
    checks++;
    if (a_ready !== 4'b0001) begin
      failures++;
      $display("FAIL post_reset_grant got=%b exp=0001", a_ready);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    a_valid = 4'hF; a_last = 4'hF; a_oready = 1'b1;
    for (int i = 0; i < 4; i++) a_data[i*16 +: 16] = 16'h1000 + 16'(i);
    #1;
    checks++;
    if (a_ready !== 4'b0001) begin
      failures++;
      $display("FAIL rr_first got=%b exp=0001", a_ready);
    end
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      checks++;
      if (a_ovalid !== 1'b1 || a_och !== 2'(k % 4)) begin
        failures++;
        $display("FAIL rr_chan k=%0d got v=%b ch=%0d exp v=1 ch=%0d", k, a_ovalid, a_och, k % 4);
      end
      checks++;
      if (a_odata !== 16'h1000 + 16'(k % 4)) begin
        failures++;
        $display("FAIL rr_data k=%0d got=%h exp=%h", k, a_odata, 16'h1000 + 16'(k % 4));
      end
      checks++;
      if (a_ready !== 4'(1 << ((k + 1) % 4))) begin
        failures++;
        $display("FAIL rr_ready k=%0d got=%b exp=%b", k, a_ready, 4'(1 << ((k + 1) % 4)));
      end
    end
    a_valid = '0;
    @(posedge clk); #1;
    checks++;
    if (a_ovalid !== 1'b0) begin
      failures++;
      $display("FAIL rr_drain got=%b exp=0", a_ovalid);
    end
  endtask

  task automatic test_burst_lock();
    logic [15:0] beats [3];
    beats[0] = 16'h000A; beats[1] = 16'h000B; beats[2] = 16'h000C;
    do_reset();
    a_oready = 1'b1;
    a_data[0 +: 16] = 16'h0010; a_data[16 +: 16] = 16'h0011;
    // Single beat from ch1 moves the pointer to ch2.
    a_valid = 4'b0010; a_last = 4'b0010;
    @(posedge clk); #1;
    a_valid = 4'b0111; a_last = 4'b0011; a_data[32 +: 16] = beats[0];
    #1;
    checks++;
    if (a_ready !== 4'b0100) begin
      failures++;
      $display("FAIL burst_start got=%b exp=0100", a_ready);
    end
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      checks++;
      if (a_och !== 2'd2 || a_odata !== beats[j] || a_olast !== (j == 2)) begin
        failures++;
        $display("FAIL burst_beat j=%0d got ch=%0d d=%h l=%b exp ch=2 d=%h l=%b",
                 j, a_och, a_odata, a_olast, beats[j], (j == 2));
      end
      if (j < 2) begin
        a_data[32 +: 16] = beats[j+1];
        if (j == 1) a_last = 4'b0111;
        #1;
        checks++;
        if (a_ready !== 4'b0100) begin
          failures++;
          $display("FAIL burst_locked j=%0d got=%b exp=0100", j, a_ready);
        end
      end
    end
    a_valid = 4'b0011;
    #1;
    checks++;
    if (a_ready !== 4'b0001) begin
      failures++;
      $display("FAIL burst_release got=%b exp=0001", a_ready);
    end
    @(posedge clk); #1;
    a_valid = 4'b0010;
    #1;
    checks++;
    if (a_och !== 2'd0 || a_odata !== 16'h0010 || a_ready !== 4'b0010) begin
      failures++;
      $display("FAIL burst_after0 got ch=%0d d=%h rdy=%b exp ch=0 d=0010 rdy=0010",
               a_och, a_odata, a_ready);
    end
    @(posedge clk); #1;
    a_valid = 4'b0000;
    checks++;
    if (a_och !== 2'd1 || a_odata !== 16'h0011) begin
      failures++;
      $display("FAIL burst_after1 got ch=%0d d=%h exp ch=1 d=0011", a_och, a_odata);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    a_valid = 4'b0001; a_last = 4'b0001; a_data[0 +: 16] = 16'h0055; a_oready = 1'b0;
    @(posedge clk); #1;
    a_data[0 +: 16] = 16'h0066;
    #1;
    checks++;
    if (a_ovalid !== 1'b1 || a_odata !== 16'h0055 || a_ready !== 4'b0000) begin
      failures++;
      $display("FAIL bp_first got v=%b d=%h rdy=%b exp v=1 d=0055 rdy=0000",
               a_ovalid, a_odata, a_ready);
    end
    for (int s = 0; s < 3; s++) begin
      @(posedge clk); #1;
      checks++;
      if (a_ovalid !== 1'b1 || a_odata !== 16'h0055 || a_ready !== 4'b0000) begin
        failures++;
        $display("FAIL bp_hold s=%0d got v=%b d=%h rdy=%b exp v=1 d=0055 rdy=0000",
                 s, a_ovalid, a_odata, a_ready);
      end
    end
    a_oready = 1'b1;
    #1;
    checks++;
    if (a_ready !== 4'b0001) begin
      failures++;
      $display("FAIL bp_release got=%b exp=0001", a_ready);
    end
    @(posedge clk); #1;
    a_valid = 4'b0000;
    checks++;
    if (a_ovalid !== 1'b1 || a_odata !== 16'h0066) begin
      failures++;
      $display("FAIL bp_next got v=%b d=%h exp v=1 d=0066", a_ovalid, a_odata);
    end
    @(posedge clk); #1;
    checks++;
    if (a_ovalid !== 1'b0) begin
      failures++;
      $display("FAIL bp_no_dup got=%b exp=0", a_ovalid);
    end
  endtask

  task automatic test_fixed_priority();
    do_reset();
    c_valid = 4'b1010; c_last = 4'b1010; c_oready = 1'b1;
    c_data[16 +: 16] = 16'h0021; c_data[48 +: 16] = 16'h0023;
    #1;
    checks++;
    if (c_ready !== 4'b0010) begin
      failures++;
      $display("FAIL prio_first got=%b exp=0010", c_ready);
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checks++;
      if (c_och !== 2'd1 || c_odata !== 16'h0021 || c_ready !== 4'b0010) begin
        failures++;
        $display("FAIL prio_hold k=%0d got ch=%0d d=%h rdy=%b exp ch=1 d=0021 rdy=0010",
                 k, c_och, c_odata, c_ready);
      end
    end
    c_valid = 4'b1000;
    #1;
    checks++;
    if (c_ready !== 4'b1000) begin
      failures++;
      $display("FAIL prio_ch3_ready got=%b exp=1000", c_ready);
    end
    @(posedge clk); #1;
    c_valid = 4'b0000;
    checks++;
    if (c_och !== 2'd3 || c_odata !== 16'h0023) begin
      failures++;
      $display("FAIL prio_ch3 got ch=%0d d=%h exp ch=3 d=0023", c_och, c_odata);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    b_oready = 1'b1;
    b_data[0 +: 16] = 16'h0030; b_data[112 +: 16] = 16'h0037;
    // Single beat from ch6 moves the pointer to ch7.
    b_valid = 8'h40; b_last = 8'hFF;
    @(posedge clk); #1;
    b_valid = 8'h81;
    #1;
    checks++;
    if (b_ready !== 8'h80) begin
      failures++;
      $display("FAIL wrap_first got=%b exp=10000000", b_ready);
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checks++;
      if (b_och !== ((k % 2 == 0) ? 3'd7 : 3'd0)) begin
        failures++;
        $display("FAIL wrap_chan k=%0d got=%0d exp=%0d", k, b_och, (k % 2 == 0) ? 7 : 0);
      end
      checks++;
      if (b_ready !== ((k % 2 == 0) ? 8'h01 : 8'h80)) begin
        failures++;
        $display("FAIL wrap_ready k=%0d got=%b exp=%b", k, b_ready,
                 (k % 2 == 0) ? 8'h01 : 8'h80);
      end
    end
    b_valid = '0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_round_robin();
    test_burst_lock();
    test_backpressure();
    test_fixed_priority();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
